// File: rtl/pushbutton_irq_reader_pkg.sv
// Shared constants for the pushbutton reader: Avalon word addresses and bus width.
package pushbutton_irq_pkg;

   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_INTMASK = 2'd1;
   localparam logic [1:0] ADDR_EDGECAP = 2'd2;
   localparam logic [1:0] ADDR_EDGESEL = 2'd3;

endpackage

// File: rtl/pushbutton_irq_reader_debounce.sv
// Per-button input path: optional inversion, synchroniser chain, and a
// stability counter that accepts a new level after DEBOUNCE_CYCLES agreeing cycles.
module pb_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] chain;
   logic [CW-1:0]          cnt;
   logic                   sync;
   logic                   accept;

   assign sync   = chain[SYNC_STAGES-1];
   assign accept = (sync != stable) && (cnt == LAST);

   // Pulses are combinational so the owner can register them on the same edge as stable.
   assign rise = accept & sync;
   assign fall = accept & ~sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         chain  <= '0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], pin ^ (ACTIVE_LOW != 0)};
         if (sync == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pushbutton_irq_reader.sv
// Avalon-MM pushbutton reader: debounced level, interrupt mask, sticky W1C
// edge capture with per-bit edge select, and a level interrupt.
module pushbutton_irq_reader
   import pushbutton_irq_pkg::*;
#(
   parameter int unsigned N_BUTTONS       = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned ACTIVE_LOW      = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 read,
   input  logic                 write,
   input  logic [DATA_W-1:0]    writedata,
   input  logic [N_BUTTONS-1:0] pushbuttons,
   output logic [DATA_W-1:0]    readdata,
   output logic                 irq
);

   logic [N_BUTTONS-1:0] level;
   logic [N_BUTTONS-1:0] rise;
   logic [N_BUTTONS-1:0] fall;
   logic [N_BUTTONS-1:0] intmask;
   logic [N_BUTTONS-1:0] edgecap;
   logic [N_BUTTONS-1:0] edgesel;
   logic [N_BUTTONS-1:0] wr_bits;
   logic [N_BUTTONS-1:0] captured;
   logic [N_BUTTONS-1:0] edgecap_next;
   logic [DATA_W-1:0]    read_mux;
   logic                 bus_rd;
   logic                 bus_wr;
   logic                 unused_wdata;

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
      pb_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .pin    (pushbuttons[i]),
         .stable (level[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   assign bus_rd       = chipselect & read;
   assign bus_wr       = chipselect & write;
   assign wr_bits      = writedata[N_BUTTONS-1:0];
   assign unused_wdata = ^writedata;
   assign captured     = (rise & ~edgesel) | (fall & edgesel);

   // Clear first, then OR in new captures so a same-cycle set beats the W1C.
   always_comb begin
      edgecap_next = edgecap;
      if (bus_wr && address == ADDR_EDGECAP) begin
         edgecap_next = edgecap & ~wr_bits;
      end
      edgecap_next = edgecap_next | captured;
   end

   always_comb begin
      read_mux = '0;
      case (address)
         ADDR_DATA:    read_mux[N_BUTTONS-1:0] = level;
         ADDR_INTMASK: read_mux[N_BUTTONS-1:0] = intmask;
         ADDR_EDGECAP: read_mux[N_BUTTONS-1:0] = edgecap;
         ADDR_EDGESEL: read_mux[N_BUTTONS-1:0] = edgesel;
         default:      read_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         intmask  <= '0;
         edgecap  <= '0;
         edgesel  <= '0;
         readdata <= '0;
      end else begin
         edgecap <= edgecap_next;
         if (bus_wr && address == ADDR_INTMASK) intmask <= wr_bits;
         if (bus_wr && address == ADDR_EDGESEL) edgesel <= wr_bits;
         if (bus_rd) readdata <= read_mux;
      end
   end

   assign irq = |(edgecap & intmask);

endmodule
